// File: rtl/bdc_pkg.sv
// Shared state type, frame-geometry defaults and index helpers for the
// barrel-distortion-correction line scheduler and the remap datapath.
package bdc_pkg;

    localparam int BDC_WIDTH        = 1920;
    localparam int BDC_HEIGHT       = 1080;
    localparam int BDC_COORD_WIDTH  = 16;
    localparam int BDC_BUFFER_LINES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ROW
    } bdc_state_t;

    function automatic int unsigned clamp_max(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

    // The ring depth is a power of two, so the modulo reduces to a mask.
    function automatic int unsigned slot_mod(input int unsigned value, input int unsigned depth);
        return value & (depth - 1);
    endfunction

endpackage

// File: rtl/bdc_line_scheduler_if.sv
// Row request / grant handshake between the remap engine (master) and the
// line scheduler (slave).
interface bdc_line_scheduler_if
    import bdc_pkg::*;
#(
    parameter int COORD_WIDTH  = BDC_COORD_WIDTH,
    parameter int BUFFER_LINES = BDC_BUFFER_LINES
);
    localparam int SLOT_W = $clog2(BUFFER_LINES);

    logic                   req_valid;
    logic [COORD_WIDTH-1:0] req_lo;
    logic [COORD_WIDTH-1:0] req_hi;
    logic                   req_ready;
    logic                   grant_valid;
    logic [COORD_WIDTH-1:0] grant_lo;
    logic [COORD_WIDTH-1:0] grant_hi;
    logic [SLOT_W-1:0]      grant_slot_base;
    logic                   grant_miss;
    logic                   row_done;

    modport master (
        output req_valid, req_lo, req_hi, row_done,
        input  req_ready, grant_valid, grant_lo, grant_hi, grant_slot_base, grant_miss
    );

    modport slave (
        input  req_valid, req_lo, req_hi, row_done,
        output req_ready, grant_valid, grant_lo, grant_hi, grant_slot_base, grant_miss
    );

endinterface

// File: rtl/bdc_window_check.sv
// Combinational check of a requested source-line window against the lines
// currently resident in the ring: clamps the range and flags misses.
module bdc_window_check
    import bdc_pkg::*;
#(
    parameter int HEIGHT       = BDC_HEIGHT,
    parameter int COORD_WIDTH  = BDC_COORD_WIDTH,
    parameter int BUFFER_LINES = BDC_BUFFER_LINES
) (
    input  logic [COORD_WIDTH-1:0] req_lo,
    input  logic [COORD_WIDTH-1:0] req_hi,
    input  logic [COORD_WIDTH-1:0] in_lines,
    input  logic [COORD_WIDTH-1:0] last_lo,
    output logic [COORD_WIDTH-1:0] lo_c,
    output logic [COORD_WIDTH-1:0] hi_c,
    output logic                   miss,
    output logic                   resident
);
    localparam logic [COORD_WIDTH-1:0] DEPTH_C = COORD_WIDTH'(BUFFER_LINES);

    logic non_monotonic;
    logic too_wide;
    logic evicted;

    // A miss is final: the engine outputs black rather than waiting forever.
    always_comb begin
        hi_c          = COORD_WIDTH'(clamp_max(32'(req_hi), HEIGHT - 1));
        lo_c          = COORD_WIDTH'(clamp_max(32'(req_lo), 32'(hi_c)));
        non_monotonic = lo_c < last_lo;
        too_wide      = (hi_c - lo_c) >= DEPTH_C;
        evicted       = (in_lines >= DEPTH_C) && (lo_c < (in_lines - DEPTH_C));
        miss          = non_monotonic || too_wide || evicted;
        resident      = hi_c < in_lines;
    end

endmodule

// File: rtl/bdc_line_scheduler.sv
// Line-buffer ring scheduler: throttles input line writes so that no line
// still needed by an output row is overwritten, and grants output rows.
module bdc_line_scheduler
    import bdc_pkg::*;
#(
    parameter int  HEIGHT       = BDC_HEIGHT,
    parameter int  COORD_WIDTH  = BDC_COORD_WIDTH,
    parameter int  BUFFER_LINES = BDC_BUFFER_LINES,
    localparam int SLOT_W       = $clog2(BUFFER_LINES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   in_line_done,
    output logic                   in_line_allow,
    output logic [SLOT_W-1:0]      wr_slot,
    output logic [COORD_WIDTH-1:0] in_lines,
    output logic                   frame_done,
    bdc_line_scheduler_if.slave    row_bus
);
    localparam logic [COORD_WIDTH-1:0]      HEIGHT_C = COORD_WIDTH'(HEIGHT);
    localparam logic signed [COORD_WIDTH:0] DEPTH_S  = (COORD_WIDTH + 1)'(BUFFER_LINES);

    bdc_state_t                    state;
    bdc_state_t                    next_state;
    logic [COORD_WIDTH-1:0]        rows_out;
    logic [COORD_WIDTH-1:0]        last_lo;
    logic [COORD_WIDTH-1:0]        lo_c;
    logic [COORD_WIDTH-1:0]        hi_c;
    logic [COORD_WIDTH-1:0]        floor_line;
    logic signed [COORD_WIDTH:0]   headroom;
    logic                          miss;
    logic                          resident;
    logic                          handshake;
    logic                          line_step;
    logic                          row_finish;
    logic                          last_row;

    bdc_window_check #(
        .HEIGHT       (HEIGHT),
        .COORD_WIDTH  (COORD_WIDTH),
        .BUFFER_LINES (BUFFER_LINES)
    ) u_window (
        .req_lo   (row_bus.req_lo),
        .req_hi   (row_bus.req_hi),
        .in_lines (in_lines),
        .last_lo  (last_lo),
        .lo_c     (lo_c),
        .hi_c     (hi_c),
        .miss     (miss),
        .resident (resident)
    );

    assign handshake  = row_bus.req_valid && row_bus.req_ready;
    assign line_step  = in_line_done && (state != IDLE) && (in_lines != HEIGHT_C);
    assign row_finish = (state == ROW) && row_bus.row_done;
    assign last_row   = rows_out == (HEIGHT_C - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (frame_start) begin
            next_state = WAIT;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                WAIT:    if (handshake) next_state = ROW;
                ROW:     if (row_bus.row_done) next_state = last_row ? IDLE : WAIT;
                default: next_state = IDLE;
            endcase
        end
    end

    // A pending non-missing request pulls the floor up, letting writes run ahead.
    always_comb begin
        row_bus.req_ready = (state == WAIT) && (miss || resident);
        floor_line        = last_lo;
        if ((state == WAIT) && row_bus.req_valid && !miss) begin
            floor_line = (lo_c > last_lo) ? lo_c : last_lo;
        end
        headroom      = $signed({1'b0, in_lines}) - $signed({1'b0, floor_line});
        in_line_allow = (state != IDLE) && (in_lines < HEIGHT_C) && (headroom < DEPTH_S);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_lines                <= '0;
            wr_slot                 <= '0;
            rows_out                <= '0;
            last_lo                 <= '0;
            frame_done              <= 1'b0;
            row_bus.grant_valid     <= 1'b0;
            row_bus.grant_lo        <= '0;
            row_bus.grant_hi        <= '0;
            row_bus.grant_slot_base <= '0;
            row_bus.grant_miss      <= 1'b0;
        end else if (frame_start) begin
            in_lines            <= '0;
            wr_slot             <= '0;
            rows_out            <= '0;
            last_lo             <= '0;
            frame_done          <= 1'b0;
            row_bus.grant_valid <= 1'b0;
        end else begin
            frame_done <= row_finish && last_row;
            if (line_step) begin
                in_lines <= in_lines + 1'b1;
                wr_slot  <= wr_slot + 1'b1;
            end
            if (handshake) begin
                row_bus.grant_valid     <= 1'b1;
                row_bus.grant_lo        <= lo_c;
                row_bus.grant_hi        <= hi_c;
                row_bus.grant_miss      <= miss;
                row_bus.grant_slot_base <= SLOT_W'(slot_mod(32'(wr_slot) - 32'(in_lines - lo_c),
                                                            BUFFER_LINES));
                if (!miss) begin
                    last_lo <= lo_c;
                end
            end else if (row_finish) begin
                row_bus.grant_valid <= 1'b0;
                rows_out            <= rows_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bdc_line_scheduler.sv
// Randomized bench for bdc_line_scheduler against a behavioural frame model.
module tb_bdc_line_scheduler;
    import bdc_pkg::*;

    localparam int H  = 8;
    localparam int CW = 16;
    localparam int BL = 4;
    localparam int SW = $clog2(BL);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          in_line_done;
    logic          in_line_allow;
    logic          frame_done;
    logic [SW-1:0] wr_slot;
    logic [CW-1:0] in_lines;

    bdc_line_scheduler_if #(.COORD_WIDTH(CW), .BUFFER_LINES(BL)) bus ();

    bdc_line_scheduler #(
        .HEIGHT       (H),
        .COORD_WIDTH  (CW),
        .BUFFER_LINES (BL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .in_line_done  (in_line_done),
        .in_line_allow (in_line_allow),
        .wr_slot       (wr_slot),
        .in_lines      (in_lines),
        .frame_done    (frame_done),
        .row_bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Frame-level view: is a frame in progress, is a row held, how far along.
    bit mActive, mGranted, mFrameDone, mGMiss;
    int mInLines, mRowsOut, mLastLo, mGLo, mGHi;
    bit eReady, eAllow, eMiss;
    int eLo, eHi;
    int pLo, pHi;
    bit sFs, sRv, sRd, sIld;
    bit didMidReset = 1'b0;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        testsRun++;
        if (got != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mActive = 0; mGranted = 0; mFrameDone = 0; mGMiss = 0;
        mInLines = 0; mRowsOut = 0; mLastLo = 0; mGLo = 0; mGHi = 0;
    endtask

    task automatic newRequest();
        if ($urandom_range(0, 5) == 0) begin
            pLo = $urandom_range(0, 12);
            pHi = $urandom_range(0, 12);
        end else begin
            pLo = mLastLo + $urandom_range(0, 2);
            pHi = pLo + $urandom_range(0, 3);
        end
    endtask

    task automatic evaluateModel(input bit rv);
        int floorLine;
        eHi   = (pHi > H - 1) ? H - 1 : pHi;
        eLo   = (pLo > eHi) ? eHi : pLo;
        eMiss = (eLo < mLastLo) || (eHi - eLo >= BL) || (mInLines >= BL && eLo < mInLines - BL);
        eReady = mActive && !mGranted && (eMiss || eHi < mInLines);
        floorLine = mLastLo;
        if (mActive && !mGranted && rv && !eMiss)
            floorLine = (eLo > mLastLo) ? eLo : mLastLo;
        eAllow = mActive && (mInLines < H) && (mInLines - floorLine < BL);
    endtask

    task automatic applyStimulus();
        sFs = mActive ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) == 0);
        sRv = ($urandom_range(0, 7) != 0);
        sRd = mGranted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        evaluateModel(sRv);
        sIld = eAllow ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        frame_start   = sFs;
        in_line_done  = sIld;
        bus.req_valid = sRv;
        bus.req_lo    = CW'(pLo);
        bus.req_hi    = CW'(pHi);
        bus.row_done  = sRd;
    endtask

    task automatic stepModel();
        if (sFs) begin
            mActive = 1; mGranted = 0; mInLines = 0; mRowsOut = 0; mLastLo = 0; mFrameDone = 0;
            newRequest();
        end else begin
            mFrameDone = 0;
            if (mActive && sIld && mInLines < H) mInLines++;
            if (sRv && eReady) begin
                mGranted = 1; mGLo = eLo; mGHi = eHi; mGMiss = eMiss;
                if (!eMiss) mLastLo = eLo;
                newRequest();
            end else if (mGranted && sRd) begin
                mGranted = 0;
                mRowsOut++;
                if (mRowsOut == H) begin
                    mActive = 0;
                    mFrameDone = 1;
                end
            end
        end
    endtask

    task automatic checkRegisters();
        checkOutput("grant_valid", bus.grant_valid, mGranted);
        checkOutput("in_lines", in_lines, mInLines);
        checkOutput("wr_slot", wr_slot, mInLines % BL);
        checkOutput("frame_done", frame_done, mFrameDone);
        if (mGranted) begin
            checkOutput("grant_lo", bus.grant_lo, mGLo);
            checkOutput("grant_hi", bus.grant_hi, mGHi);
            checkOutput("grant_slot_base", bus.grant_slot_base, mGLo % BL);
            checkOutput("grant_miss", bus.grant_miss, mGMiss);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_allow"}, in_line_allow, 0);
        checkOutput({tag, "_wr_slot"}, wr_slot, 0);
        checkOutput({tag, "_in_lines"}, in_lines, 0);
        checkOutput({tag, "_ready"}, bus.req_ready, 0);
        checkOutput({tag, "_grant_valid"}, bus.grant_valid, 0);
        checkOutput({tag, "_grant_lo"}, bus.grant_lo, 0);
        checkOutput({tag, "_grant_hi"}, bus.grant_hi, 0);
        checkOutput({tag, "_grant_slot_base"}, bus.grant_slot_base, 0);
        checkOutput({tag, "_grant_miss"}, bus.grant_miss, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic midReset();
        frame_start = 0; in_line_done = 0; bus.req_valid = 0; bus.row_done = 0;
        rst = 1;
        #1;
        checkResetOutputs("midReset");
        modelReset();
        @(negedge clk);
        rst = 0;
        in_line_done = 1;
        @(negedge clk);
        checkOutput("ignoredLine_in_lines", in_lines, 0);
        checkOutput("ignoredLine_allow", in_line_allow, 0);
        in_line_done = 0;
        didMidReset = 1;
    endtask

    initial begin
        rst = 1; frame_start = 0; in_line_done = 0;
        bus.req_valid = 0; bus.req_lo = '0; bus.req_hi = '0; bus.row_done = 0;
        modelReset();
        newRequest();
        repeat (2) @(negedge clk);
        checkResetOutputs("por");
        rst = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            checkRegisters();
            if (!didMidReset && cyc > 1000 && mGranted && mInLines >= 3) begin
                midReset();
                continue;
            end
            applyStimulus();
            #1;
            checkOutput("in_line_allow", in_line_allow, eAllow);
            checkOutput("req_ready", bus.req_ready, eReady);
            stepModel();
        end
        checkOutput("midResetReached", didMidReset, 1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bdc_line_scheduler.md
# bdc_line_scheduler

Line-buffer scheduler for the barrel-distortion-correction pipeline. It tracks which source lines are resident in the BUFFER_LINES-deep ring of line buffers. It throttles the input write path so no line is evicted while an output row still needs it, and it grants output rows to the remap engine once their whole source-line window is resident. It sits between the AXI4-Stream input write path (line counter side) and the per-pixel remap/sample datapath (row request side).

## Interface
- WIDTH, 1920: line length in pixels (informational; carried in package for consumers)
- HEIGHT, 1080: lines per frame, and output rows per frame
- COORD_WIDTH, 16: width of line/row indices
- BUFFER_LINES, 4: ring depth; must be a power of two, ≥2
- SLOT_W, $clog2(BUFFER_LINES): slot index width (derived localparam)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse: SOF pixel accepted on input stream
- in_line_done  in  1  pulse: last pixel of an input line accepted
- in_line_allow  out  1  write path may accept pixels of line `in_lines`
- wr_slot  out  SLOT_W  ring slot the current input line writes to
- in_lines  out  COORD_WIDTH  lines completed this frame
- req_valid  in  1  remap engine requests next output row
- req_lo, req_hi  in  COORD_WIDTH  inclusive source-line range for that row
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- grant_valid  out  1  row granted, active until row_done
- grant_lo, grant_hi  out  COORD_WIDTH  clamped range of granted row
- grant_slot_base  out  SLOT_W  ring slot holding grant_lo
- grant_miss  out  1  granted row's window is unavailable; engine outputs black
- row_done  in  1  pulse: engine finished the granted row
- frame_done  out  1  one-cycle pulse after HEIGHT rows completed

## Operation
- States: IDLE, WAIT, ROW.
- IDLE: allow=0, ready=0. frame_start moves to WAIT and clears in_lines, wr_slot, rows_out, last_lo.
- WAIT → ROW on handshake. ROW → WAIT on row_done. If rows_out+1==HEIGHT, ROW → IDLE instead, with frame_done pulsed.
- frame_start in any state restarts the frame: clear counters, go to WAIT. It has priority over same-cycle in_line_done/row_done and discards any active grant.
- Clamp rule: hi_c = min(req_hi, HEIGHT-1); lo_c = min(req_lo, hi_c).
- Miss if any of the following hold: lo_c < last_lo (non-monotonic); hi_c−lo_c ≥ BUFFER_LINES; in_lines ≥ BUFFER_LINES and lo_c < in_lines−BUFFER_LINES (evicted).
- req_ready in WAIT = miss OR hi_c < in_lines. Evaluation is combinational on registered state and req_* inputs.
- On handshake: grant_lo/hi ← lo_c/hi_c; grant_miss ← miss; last_lo ← miss ? last_lo : lo_c. grant_slot_base ← (wr_slot − (in_lines − lo_c)) mod BUFFER_LINES.
- Floor: in WAIT with req_valid and no miss, floor = max(lo_c, last_lo); otherwise floor = last_lo.
- in_line_allow = state≠IDLE && in_lines<HEIGHT && (in_lines − floor) < BUFFER_LINES. Compute the difference in COORD_WIDTH+1 bits signed; a negative value allows.
- in_line_done: in_lines+1, wr_slot+1 (wraps at BUFFER_LINES). Ignored in IDLE or when in_lines==HEIGHT.
- in_line_done and row_done in the same cycle: both apply. allow and ready reflect the updated counters from the next cycle.
- row_done outside ROW is ignored.

## Timing
- Reset values: in_line_allow 0, wr_slot 0, in_lines 0, req_ready 0, grant_valid 0, grant_lo/hi 0, grant_slot_base 0, grant_miss 0, frame_done 0; state IDLE.
- grant_* are registered: grant_valid rises the cycle after the handshake and falls the cycle after row_done.
- Minimum row turnaround is 2 cycles: row_done, then WAIT (ready may assert immediately).
- in_line_allow and req_ready are combinational. There is no path from req_ready to req_valid (requester must not wait on ready).
- frame_done is registered, asserted the cycle after the final row_done.

## Structure
- Package bdc_pkg holds the state enum (IDLE/WAIT/ROW) and the clamp and slot-modulo functions. It also carries the shared WIDTH/HEIGHT/BUFFER_LINES defaults used with the remap datapath.
- One sub-module: bdc_window_check. It is purely combinational and produces lo_c, hi_c, miss and resident from req_*, in_lines and last_lo, so the verification engineer can bench it standalone.

## Test plan
- Reset mid-ROW (grant_valid=1, in_lines=3) → next cycle all outputs 0, state IDLE; in_line_done is then ignored.
- HEIGHT=8, BL=4: frame_start; request lo=0,hi=2 before any line → ready=0 until in_lines=3, then grant_lo=0, grant_hi=2, grant_slot_base=0, miss=0.
- Backpressure: last_lo=1, in_lines=5, no request pending → in_line_allow=0. Request lo=3,hi=4 → allow=1 (floor 3) and the grant occurs once in_lines=5.
- Evicted line: in_lines=7, request lo=2 → immediate grant with grant_miss=1 and last_lo unchanged. Span case: lo=0, hi=5 → miss=1.
- Clamp: request lo=6, hi=12 with HEIGHT=8 → grant_hi=7, granted after in_lines=8. The 8th row_done produces frame_done for one cycle, then IDLE.
- frame_start during ROW with simultaneous row_done and in_line_done → counters 0, state WAIT, grant_valid=0, no frame_done.
